// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate vector checker: FSM states, gate op codes,
// the expected-value function and the LFSR seed/taps.
package gate_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int OP_OR   = 0;
  localparam int OP_AND  = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_NAND = 3;

  localparam logic [3:0] LFSR_SEED = 4'b1001;
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  function automatic logic expected_f(input int op, input logic d, input logic e);
    case (op)
      OP_AND:  return d & e;
      OP_XOR:  return d ^ e;
      OP_NAND: return ~(d & e);
      default: return d | e;
    endcase
  endfunction

  // Shift left, feedback is the XOR of the tapped bits (l[3]^l[2]).
  function automatic logic [3:0] lfsr_next(input logic [3:0] l);
    return {l[2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gate_vector_checker_if.sv
// Bundle between the checker (master) and its host plus the gate under test (slave).
interface gate_vector_checker_if #(
  parameter int ERR_W = 4
);
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic             drv_d;
  logic             drv_e;
  logic             obs_f;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       fail_vec;
  logic             fail_valid;

  modport master (
    input  start, obs_f,
    output busy, done, pass, drv_d, drv_e, err_cnt, fail_vec, fail_valid
  );

  modport slave (
    output start, obs_f,
    input  busy, done, pass, drv_d, drv_e, err_cnt, fail_vec, fail_valid
  );
endinterface

// File: rtl/gate_chk_lfsr.sv
// 4-bit Fibonacci LFSR for the pseudo-random vector phase; exposes only the
// two bits used as a {d,e} vector.
module gate_chk_lfsr
  import gate_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [1:0] vec
);
  logic [3:0] q;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= LFSR_SEED;
    else if (step) q <= lfsr_next(q);
  end

  assign vec = q[1:0];
endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive truth-table checker for a two-input gate. Optional LFSR vector
// phase after the sweeps is enabled with `define GATE_CHK_LFSR_EN.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int GATE_OP       = OP_OR,
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4,
  parameter int LFSR_VECTORS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_vector_checker_if.master bus
);
  localparam int SC_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int PC_W = (PASSES < 2) ? 1 : $clog2(PASSES);
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES);
  localparam logic [PC_W-1:0] LAST_PASS   = PC_W'(PASSES - 1);

  state_t          state;
  logic [1:0]      vec;
  logic [1:0]      next_vec;
  logic            more_vecs;
  logic [SC_W-1:0] settle_cnt;
  logic [PC_W-1:0] pass_cnt;
  logic            mismatch;

  assign mismatch = bus.obs_f != expected_f(GATE_OP, bus.drv_d, bus.drv_e);

`ifdef GATE_CHK_LFSR_EN
  localparam int LC_W = (LFSR_VECTORS < 2) ? 1 : $clog2(LFSR_VECTORS);
  localparam logic [LC_W-1:0] LAST_LFSR = LC_W'(LFSR_VECTORS - 1);

  logic            lfsr_phase;
  logic [LC_W-1:0] lfsr_cnt;
  logic [1:0]      lfsr_vec;

  gate_chk_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (state == S_IDLE && bus.start),
    .step (state == S_SAMPLE && lfsr_phase),
    .vec  (lfsr_vec)
  );
`endif

  // Which vector follows the one just sampled, and whether the run continues.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    more_vecs = 1'b1;
    next_vec  = vec + 2'd1;
`ifdef GATE_CHK_LFSR_EN
    if (lfsr_phase) begin
      next_vec  = lfsr_vec;
      more_vecs = (lfsr_cnt != LAST_LFSR);
    end else
`endif
    if (vec == 2'd3) begin
      if (pass_cnt != LAST_PASS) next_vec = 2'd0;
`ifdef GATE_CHK_LFSR_EN
      else if (LFSR_VECTORS > 0) next_vec = lfsr_vec;
`endif
      else more_vecs = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      vec            <= '0;
      settle_cnt     <= '0;
      pass_cnt       <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.drv_d      <= 1'b0;
      bus.drv_e      <= 1'b0;
      bus.err_cnt    <= '0;
      bus.fail_vec   <= '0;
      bus.fail_valid <= 1'b0;
`ifdef GATE_CHK_LFSR_EN
      lfsr_phase     <= 1'b0;
      lfsr_cnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          vec            <= '0;
          pass_cnt       <= '0;
          bus.err_cnt    <= '0;
          bus.fail_valid <= 1'b0;
          bus.fail_vec   <= '0;
          bus.pass       <= 1'b0;
          bus.busy       <= 1'b1;
`ifdef GATE_CHK_LFSR_EN
          lfsr_phase     <= 1'b0;
          lfsr_cnt       <= '0;
`endif
          state          <= S_DRIVE;
        end
        S_DRIVE: begin
          {bus.drv_d, bus.drv_e} <= vec;
          settle_cnt <= SETTLE_LOAD;
          state      <= (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
        end
        // One SETTLE cycle per count, so a vector spans SETTLE_CYCLES+3 clocks.
        S_SETTLE: begin
          if (settle_cnt <= SC_W'(1)) state <= S_SAMPLE;
          else                        settle_cnt <= settle_cnt - SC_W'(1);
        end
        S_SAMPLE: begin
          if (mismatch) begin
            if (!(&bus.err_cnt)) bus.err_cnt <= bus.err_cnt + ERR_W'(1);
            if (!bus.fail_valid) begin
              bus.fail_vec   <= {bus.drv_d, bus.drv_e};
              bus.fail_valid <= 1'b1;
            end
          end
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (more_vecs) begin
            vec   <= next_vec;
            state <= S_DRIVE;
            if (vec == 2'd3 && pass_cnt != LAST_PASS) pass_cnt <= pass_cnt + PC_W'(1);
`ifdef GATE_CHK_LFSR_EN
            if (vec == 2'd3 && pass_cnt == LAST_PASS) lfsr_phase <= 1'b1;
            if (lfsr_phase) lfsr_cnt <= lfsr_cnt + LC_W'(1);
`endif
          end else begin
            // Verdict and done are registered here so they appear together.
            bus.done  <= 1'b1;
            bus.pass  <= (bus.err_cnt == '0);
            bus.drv_d <= 1'b0;
            bus.drv_e <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: three checker instances (OR/settle 2, OR/2 passes/2-bit
// counter, XOR/settle 0) driven against good, faulty and stuck gate models.
module tb_gate_vector_checker;
  import gate_chk_pkg::*;

  localparam int NDUT = 3;
`ifdef GATE_CHK_LFSR_EN
  localparam int LV = 4;
`else
  localparam int LV = 0;
`endif
  localparam int N_A = 20 + LV * 5;
  localparam int N_B = 40 + LV * 5;
  localparam int N_C = 12 + LV * 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_r [NDUT];
  logic [1:0] mode_a;
  logic [1:0] mode_c;
  int n_checks = 0;
  int n_pass   = 0;

  gate_vector_checker_if #(.ERR_W(4)) a_if ();
  gate_vector_checker_if #(.ERR_W(2)) b_if ();
  gate_vector_checker_if #(.ERR_W(4)) c_if ();

  // Gate models: 0 good OR, 1 AND (wrong), 2 stuck at 0, 3 XOR.
  function automatic logic gate_model(input logic [1:0] m, input logic d, input logic e);
    case (m)
      2'd0:    return d | e;
      2'd1:    return d & e;
      2'd2:    return 1'b0;
      default: return d ^ e;
    endcase
  endfunction

  assign a_if.start = start_r[0];
  assign b_if.start = start_r[1];
  assign c_if.start = start_r[2];
  assign a_if.obs_f = gate_model(mode_a, a_if.drv_d, a_if.drv_e);
  assign b_if.obs_f = 1'b0;
  assign c_if.obs_f = gate_model(mode_c, c_if.drv_d, c_if.drv_e);

  gate_vector_checker #(.GATE_OP(OP_OR), .SETTLE_CYCLES(2), .PASSES(1), .ERR_W(4),
                        .LFSR_VECTORS(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if.master));
  gate_vector_checker #(.GATE_OP(OP_OR), .SETTLE_CYCLES(2), .PASSES(2), .ERR_W(2),
                        .LFSR_VECTORS(4)) dut_b (.clk(clk), .rst(rst), .bus(b_if.master));
  gate_vector_checker #(.GATE_OP(OP_XOR), .SETTLE_CYCLES(0), .PASSES(1), .ERR_W(4),
                        .LFSR_VECTORS(4)) dut_c (.clk(clk), .rst(rst), .bus(c_if.master));

  logic       done_w  [NDUT];
  logic       busy_w  [NDUT];
  logic       pass_w  [NDUT];
  logic       fvld_w  [NDUT];
  logic [3:0] err_w   [NDUT];
  logic [1:0] fv_w    [NDUT];
  logic [1:0] drv_w   [NDUT];

  assign done_w[0] = a_if.done;  assign done_w[1] = b_if.done;  assign done_w[2] = c_if.done;
  assign busy_w[0] = a_if.busy;  assign busy_w[1] = b_if.busy;  assign busy_w[2] = c_if.busy;
  assign pass_w[0] = a_if.pass;  assign pass_w[1] = b_if.pass;  assign pass_w[2] = c_if.pass;
  assign fvld_w[0] = a_if.fail_valid;
  assign fvld_w[1] = b_if.fail_valid;
  assign fvld_w[2] = c_if.fail_valid;
  assign err_w[0]  = a_if.err_cnt;
  assign err_w[1]  = {2'b00, b_if.err_cnt};
  assign err_w[2]  = c_if.err_cnt;
  assign fv_w[0]   = a_if.fail_vec;  assign fv_w[1] = b_if.fail_vec;  assign fv_w[2] = c_if.fail_vec;
  assign drv_w[0]  = {a_if.drv_d, a_if.drv_e};
  assign drv_w[1]  = {b_if.drv_d, b_if.drv_e};
  assign drv_w[2]  = {c_if.drv_d, c_if.drv_e};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Vector j of a run: sweeps 00..11 PASSES times, then LFSR states 1001,0011,0110,1101.
  function automatic logic [1:0] exp_vec(input int j, input int npass);
    logic [1:0] lfsr_tab [4];
    lfsr_tab = '{2'b01, 2'b11, 2'b10, 2'b01};
    if (j < 4 * npass) return 2'(j % 4);
    return lfsr_tab[j - 4 * npass];
  endfunction

  task automatic run(input int k, input string name, input int per, input int npass,
                     input int exp_n, input logic exp_pass, input logic [3:0] exp_err,
                     input logic [1:0] exp_fv, input logic exp_fvld);
    int   cyc;
    int   nvec;
    logic seen;
    nvec = 4 * npass + LV;
    @(negedge clk); start_r[k] = 1'b1;
    @(negedge clk); start_r[k] = 1'b0;
    check({name, ".busy_accept"}, busy_w[k], 1'b1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < exp_n + 50) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc >= 2 && (cyc - 2) % per == 0 && (cyc - 2) / per < nvec)
        check($sformatf("%s.drv%0d", name, (cyc - 2) / per), drv_w[k], exp_vec((cyc - 2) / per, npass));
      if (done_w[k]) seen = 1'b1;
    end
    check({name, ".done_seen"}, seen, 1'b1);
    check({name, ".done_cycle"}, cyc, exp_n);
    check({name, ".pass"}, pass_w[k], exp_pass);
    check({name, ".err_cnt"}, err_w[k], exp_err);
    check({name, ".fail_vec"}, fv_w[k], exp_fv);
    check({name, ".fail_valid"}, fvld_w[k], exp_fvld);
    check({name, ".drv_idle"}, drv_w[k], 2'b00);
    @(posedge clk); #1;
    check({name, ".done_pulse"}, done_w[k], 1'b0);
    check({name, ".busy_after"}, busy_w[k], 1'b0);
    repeat (3) @(posedge clk);
    #1 check({name, ".err_hold"}, err_w[k], exp_err);
  endtask

  initial begin
    int dones [3];
    int nd;
    int cyc;
    start_r = '{1'b0, 1'b0, 1'b0};
    mode_a  = 2'd0;
    mode_c  = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy_w[0], 1'b0);
    check("rst.done", done_w[0], 1'b0);
    check("rst.pass", pass_w[0], 1'b0);
    check("rst.err",  err_w[0], 4'd0);
    check("rst.drv",  drv_w[0], 2'b00);
    check("rst.fvld", fvld_w[1], 1'b0);
    @(negedge clk); rst = 1'b0;

    run(0, "or_good", 5, 1, N_A, 1'b1, 4'd0, 2'b00, 1'b0);
    mode_a = 2'd1;
    run(0, "or_vs_and", 5, 1, N_A, 1'b0, 4'(2 + (LV > 0 ? 3 : 0)), 2'b01, 1'b1);
    mode_a = 2'd0;
    run(0, "or_clear", 5, 1, N_A, 1'b1, 4'd0, 2'b00, 1'b0);
    run(1, "stuck_sat", 5, 2, N_B, 1'b0, 4'd3, 2'b01, 1'b1);
    run(2, "xor_s0", 3, 1, N_C, 1'b1, 4'd0, 2'b00, 1'b0);
    mode_c = 2'd0;
    run(2, "xor_vs_or", 3, 1, N_C, 1'b0, 4'(1 + (LV > 0 ? 1 : 0)), 2'b11, 1'b1);

    // Reset during SETTLE of vector 10 abandons the run.
    mode_a = 2'd1;
    @(negedge clk); start_r[0] = 1'b1;
    @(negedge clk); start_r[0] = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("midrst.pre_drv", drv_w[0], 2'b10);
    check("midrst.pre_err", err_w[0], 4'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.busy", busy_w[0], 1'b0);
    check("midrst.drv",  drv_w[0], 2'b00);
    check("midrst.err",  err_w[0], 4'd0);
    check("midrst.fvld", fvld_w[0], 1'b0);
    check("midrst.fv",   fv_w[0], 2'b00);
    check("midrst.done", done_w[0], 1'b0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done_w[0]) nd++;
    end
    check("midrst.no_done", nd, 0);
    mode_a = 2'd0;
    run(0, "post_rst", 5, 1, N_A, 1'b1, 4'd0, 2'b00, 1'b0);

    // start held high: back-to-back runs at the minimum period.
    @(negedge clk); start_r[0] = 1'b1;
    nd  = 0;
    cyc = 0;
    while (nd < 3 && cyc < 4 * (N_A + 2) + 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done_w[0]) begin
        dones[nd] = cyc;
        nd++;
      end
    end
    @(negedge clk); start_r[0] = 1'b0;
    check("held.dones", nd, 3);
    if (nd == 3) begin
      check("held.first", dones[0], N_A + 1);
      check("held.gap1", dones[1] - dones[0], N_A + 2);
      check("held.gap2", dones[2] - dones[1], N_A + 2);
    end
    repeat (4) @(posedge clk);
    #1 check("held.idle", busy_w[0], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
